// File: rtl/alu_issue.sv
// ID/EX issue stage: decodes opcode/funct3/funct7 into a 3-bit ALU opcode and registers operands.
// Optional operand forwarding is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
`ifdef ALU_ISSUE_FWD_EN
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [2:0]      ALUop,
    output logic [4:0]      out_rd,
    output logic            out_wb,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b111;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {A_ZERO, A_RS1, A_PC} a_sel_t;
    typedef enum logic [1:0] {B_ZERO, B_RS2, B_IMM} b_sel_t;

    logic            out_valid_reg;
    logic [XLEN-1:0] a_reg, b_reg;
    logic [2:0]      aluop_reg;
    logic [4:0]      rd_reg;
    logic            wb_reg;
    logic            illegal_reg;

    logic [2:0]      aluop_next;
    logic            wb_next;
    logic            illegal_next;
    logic [XLEN-1:0] a_next, b_next;
    a_sel_t          a_sel;
    b_sel_t          b_sel;
    logic            load;

    logic [XLEN-1:0] rf_data  [2];
    logic [XLEN-1:0] src_data [2];

    assign rf_data[0] = in_rs1_data;
    assign rf_data[1] = in_rs2_data;

`ifdef ALU_ISSUE_FWD_EN
    logic [4:0] src_idx [2];
    assign src_idx[0] = in_rs1;
    assign src_idx[1] = in_rs2;

    // x0 is never forwarded: a write to it must not shadow the hard-wired zero.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_data[gi] = (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == src_idx[gi]))
                                  ? fwd_data : rf_data[gi];
        end
    endgenerate
`else
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_data[gi] = rf_data[gi];
        end
    endgenerate
`endif

    assign in_ready = !flush && (!out_valid_reg || out_ready);
    assign load     = in_valid && in_ready;

    always_comb begin
        aluop_next   = OP_ADD;
        wb_next      = 1'b0;
        illegal_next = 1'b0;
        a_sel        = A_ZERO;
        b_sel        = B_ZERO;
        case (in_opcode)
            OPC_R: begin
                a_sel   = A_RS1;
                b_sel   = B_RS2;
                wb_next = 1'b1;
                case (in_funct3)
                    3'b000: begin
                        if (in_funct7 == F7_ZERO)     aluop_next = OP_ADD;
                        else if (in_funct7 == F7_ALT) aluop_next = OP_SUB;
                        else                          illegal_next = 1'b1;
                    end
                    3'b101: begin
                        if (in_funct7 == F7_ZERO)     aluop_next = OP_SRL;
                        else if (in_funct7 == F7_ALT) aluop_next = OP_SRA;
                        else                          illegal_next = 1'b1;
                    end
                    3'b001: begin
                        aluop_next   = OP_SLL;
                        illegal_next = (in_funct7 != F7_ZERO);
                    end
                    3'b100: begin
                        aluop_next   = OP_XOR;
                        illegal_next = (in_funct7 != F7_ZERO);
                    end
                    3'b110: begin
                        aluop_next   = OP_OR;
                        illegal_next = (in_funct7 != F7_ZERO);
                    end
                    3'b111: begin
                        aluop_next   = OP_AND;
                        illegal_next = (in_funct7 != F7_ZERO);
                    end
                    default: illegal_next = 1'b1;
                endcase
            end
            OPC_I: begin
                a_sel   = A_RS1;
                b_sel   = B_IMM;
                wb_next = 1'b1;
                // Shift immediates carry shamt[5] in funct7[0]; only funct7[6:1] encodes the op.
                case (in_funct3)
                    3'b000: aluop_next = OP_ADD;
                    3'b100: aluop_next = OP_XOR;
                    3'b110: aluop_next = OP_OR;
                    3'b111: aluop_next = OP_AND;
                    3'b001: begin
                        aluop_next   = OP_SLL;
                        illegal_next = (in_funct7[6:1] != 6'b000000);
                    end
                    3'b101: begin
                        if (in_funct7[6:1] == 6'b000000)      aluop_next = OP_SRL;
                        else if (in_funct7[6:1] == 6'b010000) aluop_next = OP_SRA;
                        else                                  illegal_next = 1'b1;
                    end
                    default: illegal_next = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                a_sel   = A_RS1;
                b_sel   = B_IMM;
                wb_next = 1'b1;
            end
            OPC_STORE: begin
                a_sel = A_RS1;
                b_sel = B_IMM;
            end
            OPC_LUI: begin
                b_sel   = B_IMM;
                wb_next = 1'b1;
            end
            OPC_AUIPC: begin
                a_sel   = A_PC;
                b_sel   = B_IMM;
                wb_next = 1'b1;
            end
            OPC_BRANCH: begin
                aluop_next = OP_SUB;
                a_sel      = A_RS1;
                b_sel      = B_RS2;
            end
            default: illegal_next = 1'b1;
        endcase

        // Illegal beats still flow downstream, but as an inert AND of zeros with no writeback.
        if (illegal_next) begin
            aluop_next = OP_AND;
            wb_next    = 1'b0;
            a_sel      = A_ZERO;
            b_sel      = B_ZERO;
        end
    end

    always_comb begin
        a_next = '0;
        case (a_sel)
            A_RS1:   a_next = src_data[0];
            A_PC:    a_next = in_pc;
            default: a_next = '0;
        endcase
        b_next = '0;
        case (b_sel)
            B_RS2:   b_next = src_data[1];
            B_IMM:   b_next = in_imm;
            default: b_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            aluop_reg     <= 3'b000;
            rd_reg        <= 5'd0;
            wb_reg        <= 1'b0;
            illegal_reg   <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            a_reg         <= a_next;
            b_reg         <= b_next;
            aluop_reg     <= aluop_next;
            rd_reg        <= in_rd;
            wb_reg        <= wb_next;
            illegal_reg   <= illegal_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid   = out_valid_reg;
    assign A           = a_reg;
    assign B           = b_reg;
    assign ALUop       = aluop_reg;
    assign out_rd      = rd_reg;
    assign out_wb      = wb_reg;
    assign out_illegal = illegal_reg;

endmodule
